// File: rtl/rf_multiport_sb_if.sv
// Register-file access bundle: read ports, write ports, reservation request and ready flag.
interface rf_multiport_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2
);
  logic                         ready;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic                         rsv_en;
  logic [ADDR_WIDTH-1:0]        rsv_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr
  );
endinterface

// File: rtl/rf_multiport_sb.sv
// Multi-port register file with write->read bypass, per-register busy scoreboard
// and a post-reset zeroing sweep; x0 always reads zero.
module rf_multiport_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2
) (
  input logic              clk,
  input logic              rst,
  rf_multiport_sb_if.slave bus
);
  localparam int unsigned REGS = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [REGS-1:0]         busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   regs [REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = RUN;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w]) busy_d[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
      // Applied after the clears so a same-cycle reservation keeps the register busy.
      if (bus.rsv_en) busy_d[bus.rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Array has no reset; the INIT sweep zeroes it. Later ports override earlier ones.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      regs[cnt_q] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0))
          regs[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.ready = (state_q == RUN);

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (bus.ready && (bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
        bus.rd_busy[p] = busy_q[bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] &&
              (bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            bus.rd_busy[p] = 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench for rf_multiport_sb: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_rf_multiport_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  rf_multiport_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  rf_multiport_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: edges counted since reset release, flat arrays for contents and busy.
  logic [DW-1:0]    m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  int               m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_busy <= '0;
      for (int r = 0; r < NREGS; r++) m_regs[r] <= '0;
    end else if (m_cnt < NREGS) begin
      m_cnt <= m_cnt + 1;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != 0) begin
          m_regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*DW +: DW];
          m_busy[bus.wr_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Compare process: outputs vs model, every cycle, away from the clock edges.
  always begin
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          eb;
    @(negedge clk);
    #2;
    chk("model_ready", {31'b0, bus.ready}, {31'b0, (m_cnt == NREGS)});
    for (int p = 0; p < NR; p++) begin
      a  = bus.rd_addr[p*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (m_cnt == NREGS && a != 0) begin
        ed = m_regs[a];
        eb = m_busy[a];
        for (int w = 0; w < NW; w++) begin
          if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) begin
            ed = bus.wr_data[w*DW +: DW];
            eb = 1'b0;
          end
        end
      end
      chk($sformatf("model_rd_data%0d", p), bus.rd_data[p*DW +: DW], ed);
      chk($sformatf("model_rd_busy%0d", p), {31'b0, bus.rd_busy[p]}, {31'b0, eb});
    end
  end

  task automatic idle();
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.wr_en[port]            = 1'b1;
    bus.wr_addr[port*AW +: AW] = addr;
    bus.wr_data[port*DW +: DW] = data;
  endtask

  function automatic logic [DW-1:0] rdd(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rdb(input int p);
    return {31'b0, bus.rd_busy[p]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ready", {31'b0, bus.ready}, 32'd0);
    chk("rst_busy", rdb(0), 32'd0);
    rst = 1'b0;

    // ready rises at the 32nd edge after release
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk); #2;
      chk("init_not_ready", {31'b0, bus.ready}, 32'd0);
    end
    @(negedge clk); #2;
    chk("init_ready", {31'b0, bus.ready}, 32'd1);
    for (int r = 1; r < NREGS; r++) begin
      @(negedge clk);
      bus.rd_addr = {AW'(NREGS - r), AW'(r)};
      #2;
      chk("zero_rd0", rdd(0), 32'd0);
      chk("zero_rd1", rdd(1), 32'd0);
    end

    // write/read and x0
    @(negedge clk);
    idle(); wr(0, 5'd5, 32'hDEADBEEF); bus.rd_addr = {5'd0, 5'd5};
    #2; chk("x5_bypass", rdd(0), 32'hDEADBEEF);
    @(negedge clk);
    idle(); wr(0, 5'd0, 32'h1234); bus.rd_addr = {5'd0, 5'd5};
    #2; chk("x5_read", rdd(0), 32'hDEADBEEF);
    chk("x0_same_cycle", rdd(1), 32'd0);
    @(negedge clk);
    idle(); #2; chk("x0_after", rdd(0), 32'd0);

    // write collision and bypass
    @(negedge clk);
    idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); bus.rd_addr = {5'd7, 5'd7};
    #2; chk("x7_bypass", rdd(0), 32'h22);
    @(negedge clk);
    idle(); bus.rd_addr = {5'd0, 5'd7};
    #2; chk("x7_read", rdd(0), 32'h22);

    // scoreboard
    @(negedge clk);
    idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3; bus.rd_addr = {5'd0, 5'd3};
    #2; chk("x3_rsv_same_cycle", rdb(0), 32'd0);
    @(negedge clk);
    idle(); bus.rd_addr = {5'd0, 5'd3};
    #2; chk("x3_busy", rdb(0), 32'd1);
    @(negedge clk);
    wr(1, 5'd3, 32'h55);
    #2; chk("x3_wr_busy", rdb(0), 32'd0);
    chk("x3_wr_data", rdd(0), 32'h55);
    @(negedge clk);
    idle(); bus.rd_addr = {5'd0, 5'd3};
    #2; chk("x3_cleared", rdb(0), 32'd0);
    chk("x3_data", rdd(0), 32'h55);

    // write and reserve same register in one cycle
    @(negedge clk);
    wr(0, 5'd3, 32'h66); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    @(negedge clk);
    idle(); bus.rd_addr = {5'd0, 5'd3};
    #2; chk("x3_rsv_wins", rdb(0), 32'd1);
    chk("x3_data66", rdd(0), 32'h66);

    // reset mid-operation
    @(negedge clk);
    idle(); wr(0, 5'd9, 32'hA5A5A5A5);
    @(negedge clk);
    idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    @(negedge clk);
    idle(); bus.rd_addr = {5'd3, 5'd9};
    #2; chk("x9_busy", rdb(0), 32'd1);
    chk("x9_data", rdd(0), 32'hA5A5A5A5);
    @(negedge clk);
    rst = 1'b1;
    #2; chk("midrst_ready", {31'b0, bus.ready}, 32'd0);
    chk("midrst_busy", rdb(0), 32'd0);
    chk("midrst_data", rdd(0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr(0, 5'd4, 32'h99); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4; bus.rd_addr = {5'd4, 5'd9};
    #2; chk("init_rd_zero", rdd(1), 32'd0);
    repeat (31) @(negedge clk);
    idle(); bus.rd_addr = {5'd4, 5'd9};
    #2; chk("reinit_not_ready", {31'b0, bus.ready}, 32'd0);
    begin
      int k;
      k = 0;
      while (!bus.ready && k < 8) begin
        @(negedge clk); #2;
        k++;
      end
    end
    chk("reinit_ready", {31'b0, bus.ready}, 32'd1);
    chk("x9_rezeroed", rdd(0), 32'd0);
    chk("x9_not_busy", rdb(0), 32'd0);
    chk("x4_ignored", rdd(1), 32'd0);
    chk("x4_not_busy", rdb(1), 32'd0);

    // randomized traffic, small address range to provoke collisions
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      idle();
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 2) != 0)
          wr(w, AW'($urandom_range(0, 7)), $urandom);
      end
      bus.rsv_en   = ($urandom_range(0, 2) == 0);
      bus.rsv_addr = AW'($urandom_range(0, 7));
      bus.rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      if (c == 300) rst = 1'b1;
      if (c == 303) rst = 1'b0;
    end
    @(negedge clk);
    idle();
    @(negedge clk); #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
